// File: rtl/mem_pkg.sv
// Shared types and constants for the MIPS MEM stage: access sizes, FSM states,
// base byte enables and small size/alignment helpers.
package mem_pkg;

  typedef enum logic [2:0] {
    LT_WORD  = 3'd0,
    LT_HALF  = 3'd1,
    LT_HALFU = 3'd2,
    LT_BYTE  = 3'd3,
    LT_BYTEU = 3'd4
  } load_type_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_BYTE = 4'b0001;

  function automatic logic is_byte(load_type_e lt);
    return (lt == LT_BYTE) || (lt == LT_BYTEU);
  endfunction

  function automatic logic is_half(load_type_e lt);
    return (lt == LT_HALF) || (lt == LT_HALFU);
  endfunction

  // Unknown encodings behave as word accesses.
  function automatic logic misaligned(load_type_e lt, logic [1:0] a);
    if (is_byte(lt))      return 1'b0;
    else if (is_half(lt)) return a[0];
    else                  return a != 2'b00;
  endfunction

  function automatic logic [1:0] mask_off(load_type_e lt, logic [1:0] a);
    if (is_byte(lt))      return a;
    else if (is_half(lt)) return {a[1], 1'b0};
    else                  return 2'b00;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data extraction: picks the byte/half at the given offset of a read word
// and sign- or zero-extends it to 32 bits. Purely combinational.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  load_type_e  lt,
  output logic [31:0] res
);

  logic [NUM_LANES-1:0][VEC_W-1:0] lanes;
  logic [VEC_W-1:0]                b;
  logic [15:0]                     h;

  assign lanes = rdata;
  assign b     = lanes[off];
  assign h     = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    res = rdata;
    case (lt)
      LT_BYTE:  res = {{24{b[7]}}, b};
      LT_BYTEU: res = {24'd0, b};
      LT_HALF:  res = {{16{h[15]}}, h};
      LT_HALFU: res = {16'd0, h};
      default:  res = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// MIPS MEM stage: data-memory req/ack sequencing, store lane steering, load
// extraction and the MEM/WB register. MEM_ALIGN_EXC_EN adds AdrErrMOut.
module memory_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ValidMIn,
  input  logic              RegWriteMIn,
  input  logic              MemtoRegMIn,
  input  logic              MemReadMIn,
  input  logic              MemWriteMIn,
  input  load_type_e        LoadTypeMIn,
  input  logic [31:0]       ALUOutMIn,
  input  logic [31:0]       WriteDataMIn,
  input  logic [REG_AW-1:0] WriteRegMIn,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              StallMOut,
`ifdef MEM_ALIGN_EXC_EN
  output logic              AdrErrMOut,
`endif
  output logic              RegWriteWOut,
  output logic              MemtoRegWOut,
  output logic [31:0]       ReadDataWOut,
  output logic [31:0]       ALUOutWOut,
  output logic [REG_AW-1:0] WriteRegWOut
);

  mem_state_e state, state_n;
  logic       acc, adrerr, acc_ok;
  logic [1:0] off;
  logic [3:0] be_base;
  logic [31:0] ld_res;
  logic [NUM_LANES-1:0][VEC_W-1:0] wlanes;

  assign acc = ValidMIn & (MemReadMIn | MemWriteMIn);
  assign off = mask_off(LoadTypeMIn, ALUOutMIn[1:0]);

`ifdef MEM_ALIGN_EXC_EN
  assign adrerr     = acc & misaligned(LoadTypeMIn, ALUOutMIn[1:0]);
  assign AdrErrMOut = adrerr & ~reset;
`else
  assign adrerr = 1'b0;
`endif

  assign acc_ok = acc & ~adrerr;

  // Request/stall are gated by reset so an in-flight access drops at once.
  always_comb begin
    state_n   = state;
    dmem_req  = 1'b0;
    StallMOut = 1'b0;
    case (state)
      IDLE: if (acc_ok) begin
        dmem_req = 1'b1;
        if (!dmem_ack) begin
          StallMOut = 1'b1;
          state_n   = WAIT;
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) state_n = IDLE;
        else          StallMOut = 1'b1;
      end
    endcase
    if (reset) begin
      dmem_req  = 1'b0;
      StallMOut = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Store steering: each lane picks its byte from the replicated source.
  assign be_base    = is_byte(LoadTypeMIn) ? BE_BYTE :
                      is_half(LoadTypeMIn) ? BE_HALF : BE_WORD;
  assign dmem_we    = MemWriteMIn & ~MemReadMIn;
  assign dmem_be    = dmem_we ? (be_base << off) : BE_WORD;
  assign dmem_addr  = {ALUOutMIn[ADDR_W-1:2], 2'b00};
  assign dmem_wdata = wlanes;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wlanes[i] = is_byte(LoadTypeMIn) ? WriteDataMIn[VEC_W-1:0] :
                       is_half(LoadTypeMIn) ? WriteDataMIn[(i%2)*VEC_W +: VEC_W] :
                                              WriteDataMIn[i*VEC_W +: VEC_W];
  end

  mem_load_align u_align (
    .rdata (dmem_rdata),
    .off   (off),
    .lt    (LoadTypeMIn),
    .res   (ld_res)
  );

  // MEM/WB: a stalled or faulting instruction leaves a bubble behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || StallMOut || adrerr) begin
      RegWriteWOut <= 1'b0;
      MemtoRegWOut <= 1'b0;
      ReadDataWOut <= '0;
      ALUOutWOut   <= '0;
      WriteRegWOut <= '0;
    end else begin
      RegWriteWOut <= RegWriteMIn & ValidMIn;
      MemtoRegWOut <= MemtoRegMIn;
      ReadDataWOut <= (ValidMIn & MemReadMIn) ? ld_res : 32'd0;
      ALUOutWOut   <= ALUOutMIn;
      WriteRegWOut <= WriteRegMIn;
    end
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
MEM stage of the 5-stage MIPS pipeline, directly upstream of WriteBack.
- Takes EX/MEM results and drives the data-memory req/ack interface.
- Performs store byte-lane steering and load extraction with sign/zero extension.
- Owns the MEM/WB pipeline register whose outputs feed WriteBack.
- Stalls the pipeline while a data-memory access is outstanding.

Parameters:
ADDR_W, 32, data-memory address width
REG_AW, 5, register-file index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
ValidMIn  in  1  MEM-stage instruction valid
RegWriteMIn  in  1  instruction writes the register file
MemtoRegMIn  in  1  result is taken from memory read data
MemReadMIn  in  1  load
MemWriteMIn  in  1  store
LoadTypeMIn  in  3  load/store size/sign: mem_pkg::load_type_e
ALUOutMIn  in  32  effective address or ALU result
WriteDataMIn  in  32  store data, unaligned (value in low bits)
WriteRegMIn  in  REG_AW  destination register
dmem_req  out  1  access request
dmem_we  out  1  write enable
dmem_addr  out  ADDR_W  word-aligned address ({ALUOut[31:2],2'b00})
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_ack  in  1  access complete; rdata valid this cycle
dmem_rdata  in  32  read word
StallMOut  out  1  to hazard unit: freeze F/D/E/M
RegWriteWOut  out  1  MEM/WB register → WriteBack RegWriteWIn
MemtoRegWOut  out  1  → MemtoRegWIn
ReadDataWOut  out  32  extracted/extended load data → ReadDataWIn
ALUOutWOut  out  32  → ALUOutWIn
WriteRegWOut  out  REG_AW  → WriteRegWIn

Behaviour:
- One clock domain. Reset is asynchronous and active-high: assertion clears all registered state immediately, independent of clk.
- Reset values:
  - FSM = IDLE.
  - All MEM/WB outputs = 0.
  - dmem_req = 0, so a reset mid-access drops the request; any late ack is ignored.
  - StallMOut = 0.
- Access condition: acc = ValidMIn & (MemReadMIn | MemWriteMIn).
- FSM IDLE:
  - If acc: dmem_req=1 combinationally in the same cycle.
    - dmem_ack=1 that cycle → access completes; stay in IDLE; StallMOut=0 (zero-wait-state).
    - Otherwise → go to WAIT; StallMOut=1.
- FSM WAIT:
  - dmem_req=1; addr, we, be, and wdata held stable (inputs are frozen by the stall).
  - StallMOut=1 until the cycle dmem_ack=1.
  - On ack: StallMOut=0 that cycle; return to IDLE.
- dmem_ack outside a request is ignored.
- Store lanes (addr[1:0] = a):
  - word: be=1111, only a=00 legal.
  - half: be=0011<<a, wdata={2{WriteData[15:0]}}, only a[0]=0 legal.
  - byte: be=0001<<a, wdata={4{WriteData[7:0]}}.
- Loads: be=1111, dmem_we=0.
- Load extract: selects byte/half at a from dmem_rdata; sign-extends for LT_BYTE/LT_HALF, zero-extends for LT_BYTEU/LT_HALFU; word passes through.
- MEM/WB register (latency 1), updated every clk edge:
  - StallMOut=0: captures RegWrite&ValidMIn, MemtoReg, extracted load data (0 for non-loads), ALUOut, WriteReg.
  - StallMOut=1: loads a bubble (RegWriteWOut=0, other fields 0). WriteBack never sees a duplicate or partial result.
- Back-to-back accesses: a new acc in the cycle after an ack issues immediately. No dead cycle is required.
- Non-memory instructions pass through with one-cycle latency and never stall.

Optional Feature:
MEM_ALIGN_EXC_EN
- Defined:
  - Adds output AdrErrMOut (1 bit).
  - Misaligned word (a≠00) or half (a[0]=1) access → AdrErrMOut=1 combinationally; dmem_req suppressed; no stall.
  - MEM/WB captures a bubble.
- Undefined:
  - No extra port.
  - Illegal low address bits are masked: word forces a=00, half forces a[0]=0. The access proceeds.

Decomposition:
- mem_pkg holds:
  - load_type_e: LT_WORD, LT_HALF, LT_HALFU, LT_BYTE, LT_BYTEU.
  - mem_state_e: IDLE, WAIT.
  - Byte-enable constants BE_WORD, BE_HALF, BE_BYTE.
- One sub-module, mem_load_align: purely combinational rdata/offset/type → extended 32-bit result.
  - Shared with the bench's reference model.

Test Plan:
- Zero-wait load: LT_WORD, addr 0x100, ack same cycle, rdata 0xDEADBEEF → StallMOut never 1; next cycle ReadDataWOut=0xDEADBEEF, MemtoRegWOut=1, RegWriteWOut=1.
- Wait-state load: LT_BYTE, addr 0x103, ack after 3 cycles, rdata 0x80112233 → StallMOut=1 for 3 cycles with bubbles in W; ReadDataWOut=0xFFFFFF80 (LT_BYTEU → 0x00000080).
- Half store: addr 0x06, data 0x0000ABCD → dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1, RegWriteWOut=0 after ack.
- Reset mid-access: assert reset while in WAIT → dmem_req=0, W outputs 0 immediately; later ack ignored; next instruction ALU add with ALUOut 5 → ALUOutWOut=5.
- Back-to-back: load (ack 1 wait) then store (ack 0 wait) → store dmem_req asserted in the cycle after the load's ack; exactly one W result per instruction.
- Misaligned word addr 0x102:
  - with MEM_ALIGN_EXC_EN: AdrErrMOut=1, no dmem_req, W bubble.
  - without: dmem_addr=0x100, be=1111.
